lsu_bridge: RTL
===============

# lsu_bridge

Load/store bridge directly downstream of the core's memory port. It consumes the core's combinational memory request (`rmem`/`wmem`, `mem_addr`, `mem_wdata`, `mem_type`, `mem_sign`) and converts it into a word-aligned, byte-enabled req/ack bus transaction. While the access is in flight it stalls the core through `busy`, then returns lane-aligned, sign- or zero-extended load data on `mem_rdata`.

## Interface
- `TIMEOUT`, default 255: bus cycles to wait for `bus_ack` before aborting. Used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rmem` in 1: core load request.
- `wmem` in 1: core store request.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, right-aligned.
- `mem_type` in 2: access size. 00 byte, 01 half, 10 word; 11 treated as word.
- `mem_sign` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `mem_rdata` out 32: extended load data.
- `busy` out 1: stall request to the core's hazard unit.
- `bus_req` out 1: bus transaction valid.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: `{mem_addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: one-cycle completion strobe.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `err` out 1: one-cycle pulse on a misaligned or aborted access.
- `err_code` out 2: 01 misaligned, 10 timeout; holds last value.

## Operation
- FSM states IDLE, REQ, DONE. Reset state is IDLE.
- IDLE:
  - If `rmem|wmem`, assert `busy` combinationally in the same cycle and latch addr, data, type, sign and we.
  - If `rmem` and `wmem` are both high, the access is a write.
  - If the access is aligned, go to REQ.
  - If misaligned (half with addr[0]=1, or word with addr[1:0]≠0), go directly to DONE with the error flagged. No bus access is made; the load returns 0 and the store is dropped.
- REQ:
  - `bus_req`=1. All bus outputs are held stable from the latched values.
  - On `bus_ack`, capture the extended read data and go to DONE.
- DONE:
  - `busy`=0 so the core retires the instruction. `mem_rdata` is valid.
  - `err` pulses here if flagged.
  - Next state is IDLE unconditionally, even if `rmem|wmem` is still high. Each instruction is therefore served exactly once.
- Byte enables: byte `4'b0001<<a[1:0]`; half `4'b0011<<{a[1],1'b0}`; word `4'b1111`.
- Write data: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- Read data:
  - Select the byte lane from a[1:0] or the half lane from a[1].
  - Bit 7 or bit 15 is replicated upward when `mem_sign`=1; otherwise the upper bits are zero-filled.
  - Word loads pass through unchanged.
- `mem_rdata` is registered. It holds its value until the next captured load, and is cleared to 0 on a misaligned load or a timeout.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `mem_rdata`=0, `err`=0, `err_code`=0, state IDLE. `busy` is 0 unless a request is present in IDLE.
- Aligned access with the request at cycle N:
  - N: IDLE, `busy`=1.
  - N+1: REQ.
  - Ack at cycle M ≥ N+1, then M+1 is DONE with `busy`=0.
  - M+2 is IDLE.
  - Minimum core stall: 2 cycles.
- Misaligned access: N is IDLE with `busy`=1; N+1 is DONE with `err`=1; N+2 is IDLE.
- `rst` asserted in REQ:
  - The next edge returns the block to IDLE and drops `bus_req`.
  - An ack for the abandoned transaction is ignored.
  - No `err` pulse is produced.
- `busy` is a combinational function of state, `rmem` and `wmem` only. It never depends on `bus_ack` in the same cycle.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8+ bit counter is cleared on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT`, the FSM goes to DONE with `err_code`=10, `mem_rdata`=0, and `bus_req` deasserted.
  - Ack in the same cycle as expiry wins; that is not a timeout.
- Undefined: no counter is built, REQ waits indefinitely, and `err_code`=10 never occurs.

## Test plan
- LW at 0x100, ack after 3 REQ cycles with rdata 0x8899AABB: `bus_be`=1111, `busy` high for 4 cycles, `mem_rdata`=0x8899AABB in DONE.
- LB at 0x103 with `mem_sign`=1 and rdata 0x80FFFFFF: `bus_be`=1000, `mem_rdata`=0xFFFFFF80. Repeat as LBU: 0x00000080.
- SH at 0x102 with wdata 0x1234ABCD: `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_addr`=0x100.
- LW at 0x101: no `bus_req`; `err`=1 for 1 cycle, `err_code`=01, `mem_rdata`=0, `busy` high for exactly 1 cycle.
- With `LSU_TIMEOUT_EN` and `TIMEOUT`=4, a load with no ack: DONE after 4 REQ cycles, `err_code`=10. With ack on cycle 4: normal completion.
- `rst` pulsed in REQ followed by a stray `bus_ack`: state IDLE, `bus_req`=0, `mem_rdata` unchanged from reset (0).

Source files
------------

// File: rtl/lsu_bridge.sv
// Load/store bridge: turns the core's combinational memory request into a word-aligned,
// byte-enabled req/ack bus transaction. Optional bus timeout under macro LSU_TIMEOUT_EN.
module lsu_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rmem,
    input  logic        wmem,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_type,
    input  logic        mem_sign,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t     state;
    logic [1:0] a_lo;
    logic [1:0] typ;
    logic       sgn;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt;
`else
    localparam logic [31:0] TIMEOUT_BITS = TIMEOUT;
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_BITS;
`endif

    function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
        case (t)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] t, input logic [1:0] a);
        case (t)
            2'b00:   be_of = 4'b0001 << a;
            2'b01:   be_of = a[1] ? 4'b1100 : 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b00:   wdata_of = {4{d[7:0]}};
            2'b01:   wdata_of = {2{d[15:0]}};
            default: wdata_of = d;
        endcase
    endfunction

    // Lane select followed by sign or zero extension; words pass through untouched.
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] a,
                                             input logic [1:0] t, input logic s);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (t)
            2'b00:   load_ext = {{24{s & b[7]}}, b};
            2'b01:   load_ext = {{16{s & h[15]}}, h};
            default: load_ext = d;
        endcase
    endfunction

    // Stall the core while a request waits in IDLE or a transaction is in flight.
    always_comb begin
        case (state)
            IDLE:    busy = rmem | wmem;
            REQ:     busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Request FSM with registered bus, error and load-data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_lo      <= 2'b00;
            typ       <= 2'b00;
            sgn       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
            mem_rdata <= 32'h0000_0000;
            err       <= 1'b0;
            err_code  <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rmem | wmem) begin
                        a_lo <= mem_addr[1:0];
                        typ  <= mem_type;
                        sgn  <= mem_sign;
                        if (misaligned(mem_type, mem_addr[1:0])) begin
                            state    <= DONE;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            if (!wmem) begin
                                mem_rdata <= 32'h0000_0000;
                            end else begin
                                mem_rdata <= mem_rdata;
                            end
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= wmem;
                            bus_addr  <= {mem_addr[31:2], 2'b00};
                            bus_be    <= be_of(mem_type, mem_addr[1:0]);
                            bus_wdata <= wdata_of(mem_type, mem_wdata);
`ifdef LSU_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // Ack beats an expiry that lands in the same cycle.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            mem_rdata <= load_ext(bus_rdata, a_lo, typ, sgn);
                        end else begin
                            mem_rdata <= mem_rdata;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        bus_req   <= 1'b0;
                        mem_rdata <= 32'h0000_0000;
                        err       <= 1'b1;
                        err_code  <= 2'b10;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`else
                    else begin
                        state <= REQ;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
